// File: rtl/pipe_ctrl_stage_pkg.sv
// Shared control-bundle layout, forwarding encodings and bubble constants
// for the pipeline control stage.
package pipe_ctrl_stage_pkg;

  localparam int unsigned EX_W  = 4;
  localparam int unsigned MEM_W = 3;
  localparam int unsigned WB_W  = 2;
  localparam int unsigned FWD_W = 2;

  localparam int unsigned EX_REGDST    = 3;
  localparam int unsigned EX_ALUSRC    = 0;
  localparam int unsigned MEM_MEMREAD  = 2;
  localparam int unsigned MEM_MEMWRITE = 1;
  localparam int unsigned MEM_MEMTOREG = 0;
  localparam int unsigned WB_REGWRITE  = 1;
  localparam int unsigned WB_MEMTOREG  = 0;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
  } ctrl_t;

  localparam logic [EX_W-1:0]  EX_BUBBLE   = '0;
  localparam logic [MEM_W-1:0] MEM_BUBBLE  = '0;
  localparam logic [WB_W-1:0]  WB_BUBBLE   = '0;
  localparam ctrl_t            CTRL_BUBBLE = '{ex: EX_BUBBLE, mem: MEM_BUBBLE, wb: WB_BUBBLE};

endpackage

// File: rtl/pipe_ctrl_stage_forwarding_unit.sv
// EX-stage operand forwarding selects; EX/MEM results take precedence over MEM/WB.
module forwarding_unit
  import pipe_ctrl_stage_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_regwrite,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b
);

  logic mem_live;
  logic wb_live;

  // Writes to $0 are never forwarded.
  assign mem_live = mem_regwrite && (mem_dest != '0);
  assign wb_live  = wb_regwrite  && (wb_dest  != '0);

  function automatic logic [FWD_W-1:0] select_src(input logic [REG_W-1:0] src);
    if (mem_live && (mem_dest == src)) return FWD_MEM;
    if (wb_live  && (wb_dest  == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    fwd_a = select_src(ex_rs);
    fwd_b = select_src(ex_rt);
  end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall, branch/jump
// squash, forwarding selects and saturating stall/flush counters.
module pipe_ctrl_stage
  import pipe_ctrl_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [EX_W-1:0]  id_ex,
  input  logic [MEM_W-1:0] id_mem,
  input  logic [WB_W-1:0]  id_wb,
  input  logic             id_jump,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_taken,
  output logic [EX_W-1:0]  ex_ctrl,
  output logic [MEM_W-1:0] mem_ctrl,
  output logic [WB_W-1:0]  wb_ctrl,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic [REG_W-1:0] wb_dest,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_t            idex;
  logic [REG_W-1:0] idex_rd;
  logic [MEM_W-1:0] exmem_mem;
  logic [WB_W-1:0]  exmem_wb;
  logic [REG_W-1:0] mem_dest;
  logic [WB_W-1:0]  memwb_wb;

  logic             stall;
  logic             flush;
  logic             idex_bubble;
  logic [REG_W-1:0] ex_dest;

  // Hazard detection; a taken branch and reset both override the stall.
  always_comb begin
    stall       = 1'b0;
    flush       = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      stall = !ex_taken && id_valid && idex.mem[MEM_MEMREAD] && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (ex_rt == id_rt));
      flush = ex_taken || (id_jump && id_valid && !stall);
    end
    idex_bubble = ex_taken || stall || !id_valid;
  end

  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign ifid_flush = flush;

  assign ex_dest = idex.ex[EX_REGDST] ? idex_rd : ex_rt;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex      <= CTRL_BUBBLE;
      ex_rs     <= '0;
      ex_rt     <= '0;
      idex_rd   <= '0;
      exmem_mem <= MEM_BUBBLE;
      exmem_wb  <= WB_BUBBLE;
      mem_dest  <= '0;
      memwb_wb  <= WB_BUBBLE;
      wb_dest   <= '0;
    end else begin
      if (idex_bubble) begin
        idex    <= CTRL_BUBBLE;
        ex_rs   <= '0;
        ex_rt   <= '0;
        idex_rd <= '0;
      end else begin
        idex    <= '{ex: id_ex, mem: id_mem, wb: id_wb};
        ex_rs   <= id_rs;
        ex_rt   <= id_rt;
        idex_rd <= id_rd;
      end
      exmem_mem <= idex.mem;
      exmem_wb  <= idex.wb;
      mem_dest  <= ex_dest;
      memwb_wb  <= exmem_wb;
      wb_dest   <= mem_dest;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign ex_ctrl  = idex.ex;
  assign mem_ctrl = exmem_mem;
  assign wb_ctrl  = memwb_wb;

  forwarding_unit #(
    .REG_W (REG_W)
  ) u_fwd (
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_dest     (mem_dest),
    .mem_regwrite (exmem_wb[WB_REGWRITE]),
    .wb_dest      (wb_dest),
    .wb_regwrite  (memwb_wb[WB_REGWRITE]),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Randomized and directed bench for pipe_ctrl_stage against an
// instruction-level pipeline model.
module tb_pipe_ctrl_stage;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [3:0]       id_ex;
  logic [2:0]       id_mem;
  logic [1:0]       id_wb;
  logic             id_jump;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             ex_taken;
  logic [3:0]       ex_ctrl;
  logic [2:0]       mem_ctrl;
  logic [1:0]       wb_ctrl;
  logic [REG_W-1:0] ex_rs, ex_rt, wb_dest;
  logic [1:0]       fwd_a, fwd_b;
  logic             pc_write, ifid_write, ifid_flush;
  logic [CNT_W-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipe_ctrl_stage #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ex(id_ex), .id_mem(id_mem),
    .id_wb(id_wb), .id_jump(id_jump), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_taken(ex_taken), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_dest(wb_dest),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // One in-flight instruction; index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic [3:0]       ex;
    logic [2:0]       mem;
    logic [1:0]       wb;
    logic [REG_W-1:0] rs, rt, rd;
  } instr_t;

  instr_t      pipe [3];
  int unsigned m_stall, m_flush;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REG_W-1:0] dst(input instr_t i);
    return i.ex[3] ? i.rd : i.rt;
  endfunction

  function automatic logic [1:0] src_sel(input logic [REG_W-1:0] r);
    if (pipe[1].wb[1] && dst(pipe[1]) != 0 && dst(pipe[1]) == r) return 2'b10;
    if (pipe[2].wb[1] && dst(pipe[2]) != 0 && dst(pipe[2]) == r) return 2'b01;
    return 2'b00;
  endfunction

  // Compare every output against the model at the falling edge, then advance the model.
  task automatic cycle();
    logic st, fl;
    @(negedge clk);
    st = !rst && !ex_taken && id_valid && pipe[0].mem[2] && pipe[0].rt != 0 &&
         (pipe[0].rt == id_rs || pipe[0].rt == id_rt);
    fl = !rst && (ex_taken || (id_jump && id_valid && !st));
    check("ex_ctrl",     32'(ex_ctrl),     32'(pipe[0].ex));
    check("mem_ctrl",    32'(mem_ctrl),    32'(pipe[1].mem));
    check("wb_ctrl",     32'(wb_ctrl),     32'(pipe[2].wb));
    check("ex_rs",       32'(ex_rs),       32'(pipe[0].rs));
    check("ex_rt",       32'(ex_rt),       32'(pipe[0].rt));
    check("wb_dest",     32'(wb_dest),     32'(dst(pipe[2])));
    check("fwd_a",       32'(fwd_a),       32'(src_sel(pipe[0].rs)));
    check("fwd_b",       32'(fwd_b),       32'(src_sel(pipe[0].rt)));
    check("pc_write",    32'(pc_write),    32'(!st));
    check("ifid_write",  32'(ifid_write),  32'(!st));
    check("ifid_flush",  32'(ifid_flush),  32'(fl));
    check("stall_count", 32'(stall_count), m_stall);
    check("flush_count", 32'(flush_count), m_flush);
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (st && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (ex_taken || st || !id_valid) pipe[0] = '0;
      else pipe[0] = '{ex: id_ex, mem: id_mem, wb: id_wb, rs: id_rs, rt: id_rt, rd: id_rd};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                       input int rs, input int rt, input int rd);
    id_valid = 1'b1; id_jump = 1'b0; ex_taken = 1'b0;
    id_ex = ex; id_mem = mem; id_wb = wb;
    id_rs = REG_W'(rs); id_rt = REG_W'(rt); id_rd = REG_W'(rd);
  endtask

  task automatic idle();
    drive(4'b0, 3'b0, 2'b0, 0, 0, 0);
    id_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 4; i++) cycle();
  endtask

  initial begin
    int unsigned f0, s0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_stall = 0; m_flush = 0;
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    check("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);

    // R-type latency through the stages
    drive(4'b1100, 3'b000, 2'b10, 1, 2, 3);
    cycle();
    check("rtype_ex", 32'(ex_ctrl), 32'hC);
    idle(); cycle(); cycle();
    check("rtype_wb", 32'(wb_ctrl), 32'h2);
    check("rtype_wbdest", 32'(wb_dest), 32'd3);
    drain();

    // lw $5 then add using $5: one stall, bubble, then MEM/WB forward
    drive(4'b0001, 3'b101, 2'b11, 1, 5, 0);
    cycle();
    drive(4'b1100, 3'b000, 2'b10, 5, 6, 7);
    #1;
    check("lu_pc_write", 32'(pc_write), 32'd0);
    check("lu_ifid_write", 32'(ifid_write), 32'd0);
    cycle();
    check("lu_bubble", 32'(ex_ctrl), 32'd0);
    check("lu_stall_count", 32'(stall_count), 32'd1);
    cycle();
    check("lu_fwd_a", 32'(fwd_a), 32'b01);
    drain();

    // EX/MEM forward, MEM/WB forward with a gap, and no forward from $0
    drive(4'b1100, 3'b000, 2'b10, 1, 2, 4); cycle();
    drive(4'b1100, 3'b000, 2'b10, 4, 4, 8); cycle();
    check("fwd_mem_a", 32'(fwd_a), 32'b10);
    check("fwd_mem_b", 32'(fwd_b), 32'b10);
    drain();
    drive(4'b1100, 3'b000, 2'b10, 1, 2, 4); cycle();
    drive(4'b1100, 3'b000, 2'b10, 9, 10, 11); cycle();
    drive(4'b1100, 3'b000, 2'b10, 4, 4, 8); cycle();
    check("fwd_wb_a", 32'(fwd_a), 32'b01);
    check("fwd_wb_b", 32'(fwd_b), 32'b01);
    drain();
    drive(4'b1100, 3'b000, 2'b10, 1, 2, 0); cycle();
    drive(4'b1100, 3'b000, 2'b10, 0, 0, 8); cycle();
    check("fwd_zero", 32'(fwd_a), 32'b00);
    drain();

    // Taken branch beats a pending load-use stall
    drive(4'b0001, 3'b101, 2'b11, 1, 5, 0); cycle();
    drive(4'b1100, 3'b000, 2'b10, 5, 6, 7);
    ex_taken = 1'b1;
    #1;
    check("br_flush", 32'(ifid_flush), 32'd1);
    check("br_pc_write", 32'(pc_write), 32'd1);
    f0 = m_flush; s0 = m_stall;
    cycle();
    check("br_bubble", 32'(ex_ctrl), 32'd0);
    check("br_flush_count", 32'(flush_count), f0 + 1);
    check("br_stall_count", 32'(stall_count), s0);
    drain();

    // Jump flushes one cycle; invalid ID is a silent bubble
    drive(4'b0000, 3'b000, 2'b00, 0, 0, 0);
    id_jump = 1'b1;
    #1;
    check("jmp_flush", 32'(ifid_flush), 32'd1);
    cycle();
    idle(); #1;
    check("jmp_flush_off", 32'(ifid_flush), 32'd0);
    cycle();
    drain();

    // Reset with three instructions in flight
    drive(4'b1100, 3'b000, 2'b10, 1, 2, 3); cycle();
    drive(4'b0001, 3'b101, 2'b11, 2, 6, 0); cycle();
    drive(4'b0001, 3'b010, 2'b00, 3, 7, 0); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst_mid_ex", 32'(ex_ctrl), 32'd0);
    check("rst_mid_mem", 32'(mem_ctrl), 32'd0);
    check("rst_mid_wb", 32'(wb_ctrl), 32'd0);

    // Counter saturation
    for (int i = 0; i < int'(CMAX) + 4; i++) begin
      drive(4'b0001, 3'b101, 2'b11, 0, 5, 0); cycle();
      drive(4'b1100, 3'b000, 2'b10, 5, 6, 7); cycle();
    end
    check("stall_sat", 32'(stall_count), CMAX);
    idle();
    ex_taken = 1'b1;
    for (int i = 0; i < int'(CMAX) + 4; i++) cycle();
    check("flush_sat", 32'(flush_count), CMAX);
    ex_taken = 1'b0;
    drain();

    // Random traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_jump  = ($urandom_range(0, 7) == 0);
      ex_taken = ($urandom_range(0, 7) == 0);
      id_ex    = 4'($urandom);
      id_mem   = 3'($urandom);
      id_wb    = 2'($urandom);
      id_rs    = REG_W'($urandom_range(0, 7));
      id_rt    = REG_W'($urandom_range(0, 7));
      id_rd    = REG_W'($urandom_range(0, 7));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
